// File: rtl/frame_timing_gen.sv
// Raster timing generator (SVGA 800x600@60 by default) on the pixel clock.
// Every output is a register decoded from the next-state counters, so outputs describe the current pixel with no lag.
module frame_timing_gen #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic       clk40,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       videoActive,
  output logic [9:0] hPos,
  output logic [9:0] vPos,
  output logic       nextFrameActive
);

  localparam logic [10:0] H_VIS_C   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0]  V_VIS_C   = 10'(V_VISIBLE);
  localparam logic [9:0]  V_PRE_C   = 10'(V_VISIBLE - 1);
  localparam logic [9:0]  V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic        SYNC_IDLE = ~SYNC_POL;

  logic [10:0] hCount;
  logic [9:0]  vCount;
  logic [10:0] hNext;
  logic [9:0]  vNext;
  logic        hVisNext;
  logic        vVisNext;
  logic        hSyncNext;
  logic        vSyncNext;
  logic        preFetchNext;

  always_comb begin
    hNext = (hCount == H_LAST) ? '0 : hCount + 11'd1;
    vNext = vCount;
    if (hCount == H_LAST) begin
      vNext = (vCount == V_LAST) ? '0 : vCount + 10'd1;
    end
  end

  // Decoding the next counter values lets the output registers line up with the counters.
  always_comb begin
    hVisNext     = (hNext < H_VIS_C);
    vVisNext     = (vNext < V_VIS_C);
    hSyncNext    = (hNext >= H_SYNC_LO) && (hNext < H_SYNC_HI);
    vSyncNext    = (vNext >= V_SYNC_LO) && (vNext < V_SYNC_HI);
    preFetchNext = (vNext < V_PRE_C) || (vNext == V_LAST);
  end

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      hCount          <= H_LAST;
      vCount          <= V_LAST;
      hsync           <= SYNC_IDLE;
      vsync           <= SYNC_IDLE;
      videoActive     <= 1'b0;
      hPos            <= '0;
      vPos            <= '0;
      nextFrameActive <= 1'b0;
    end else begin
      hCount          <= hNext;
      vCount          <= vNext;
      hsync           <= hSyncNext ^ SYNC_IDLE;
      vsync           <= vSyncNext ^ SYNC_IDLE;
      videoActive     <= hVisNext && vVisNext;
      hPos            <= hVisNext ? hNext[9:0] : '0;
      vPos            <= vNext;
      nextFrameActive <= preFetchNext;
    end
  end

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench: full-size SVGA instance for line-level timing and async reset,
// plus a shrunken negative-polarity instance for whole-frame behaviour.
`timescale 1ns/1ps
module tb_frame_timing_gen;

  logic       clk40 = 1'b0;
  logic       reset;
  logic       hsync, vsync, videoActive, nextFrameActive;
  logic [9:0] hPos, vPos;
  logic       sHsync, sVsync, sVideoActive, sNextFrameActive;
  logic [9:0] sHPos, sVPos;

  int tests;
  int failed;

  always #12 clk40 = ~clk40;

  frame_timing_gen dut (
    .clk40(clk40), .reset(reset), .hsync(hsync), .vsync(vsync),
    .videoActive(videoActive), .hPos(hPos), .vPos(vPos),
    .nextFrameActive(nextFrameActive)
  );

  // Small frame: H_TOTAL = 16 (sync 10..12), V_TOTAL = 11 (sync lines 7..8), active-low syncs.
  frame_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
  ) dutSmall (
    .clk40(clk40), .reset(reset), .hsync(sHsync), .vsync(sVsync),
    .videoActive(sVideoActive), .hPos(sHPos), .vPos(sVPos),
    .nextFrameActive(sNextFrameActive)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk40);
  endtask

  task automatic check_big(input string tag, input logic hs, input logic vs, input logic va,
                           input int hp, input int vp, input logic nfa);
    check({tag, ".hsync"}, 32'(hsync), 32'(hs));
    check({tag, ".vsync"}, 32'(vsync), 32'(vs));
    check({tag, ".videoActive"}, 32'(videoActive), 32'(va));
    check({tag, ".hPos"}, 32'(hPos), 32'(hp));
    check({tag, ".vPos"}, 32'(vPos), 32'(vp));
    check({tag, ".nextFrameActive"}, 32'(nextFrameActive), 32'(nfa));
  endtask

  initial begin
    int h, v, vaCount, vsCycles, frame;
    logic expHs, expVs, expVa, expNfa;
    int expHp;
    tests = 0;
    failed = 0;
    reset = 1'b1;
    #1;
    check_big("reset_async", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("reset_async.small_hsync", 32'(sHsync), 32'd1);
    check("reset_async.small_vsync", 32'(sVsync), 32'd1);
    step(5);
    check_big("reset_held", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    reset = 1'b0;

    // Cycle n (n-th edge after release) shows hCount = n-1 on line 0.
    step(1);
    check_big("cyc1_origin", 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    step(799);
    check_big("cyc800_last_visible", 1'b0, 1'b0, 1'b1, 799, 0, 1'b1);
    step(1);
    check_big("cyc801_front_porch", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(39);
    check_big("hcount839", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(1);
    check_big("hcount840_hsync_rise", 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    step(127);
    check_big("hcount967_hsync_high", 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    step(1);
    check_big("hcount968_hsync_fall", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(87);
    check_big("hcount1055_line_end", 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(1);
    check_big("line1_start", 1'b0, 1'b0, 1'b1, 0, 1, 1'b1);
    step(850);
    check_big("line1_px850", 1'b1, 1'b0, 1'b0, 0, 1, 1'b1);

    // Mid-line reset while hsync is active: outputs must drop without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_big("midline_reset", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(3);
    check_big("midline_reset_held", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    step(1);
    check_big("restart_origin", 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);

    // Three small frames, each cycle compared against the raster model.
    vaCount = 0;
    vsCycles = 0;
    frame = 0;
    for (int k = 1; k <= 3 * 176; k++) begin
      if (k > 1) step(1);
      h = (k - 1) % 16;
      v = ((k - 1) / 16) % 11;
      expVa  = (h < 8) && (v < 6);
      expHp  = (h < 8) ? h : 0;
      expHs  = !((h >= 10) && (h < 13));
      expVs  = !((v >= 7) && (v < 9));
      expNfa = (v < 5) || (v == 10);
      check("small.videoActive", 32'(sVideoActive), 32'(expVa));
      check("small.hPos", 32'(sHPos), 32'(expHp));
      check("small.vPos", 32'(sVPos), 32'(v));
      check("small.hsync", 32'(sHsync), 32'(expHs));
      check("small.vsync", 32'(sVsync), 32'(expVs));
      check("small.nextFrameActive", 32'(sNextFrameActive), 32'(expNfa));
      if (sVideoActive) vaCount++;
      if (!sVsync) vsCycles++;
      if (h == 15 && v == 10) begin
        frame++;
        check("small.frame_active_cycles", 32'(vaCount), 32'd48);
        check("small.frame_vsync_cycles", 32'(vsCycles), 32'd32);
        vaCount = 0;
        vsCycles = 0;
      end
    end
    check("small.frames_seen", 32'(frame), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
